// File: rtl/sprite_pixel_fetch_if.sv
// Sprite staging-write and sprite-ROM bus between the pixel fetcher and its controller/ROM.
// Carries hflip_in only when SPRITE_HFLIP_EN is defined.
interface sprite_pixel_fetch_if #(
  parameter int DATA_WIDTH = 24,
  parameter int SPR_W_LOG2 = 5,
  parameter int SPR_H_LOG2 = 5,
  parameter int FRAME_BITS = 2
);
  localparam int ADDR_WIDTH = FRAME_BITS + SPR_W_LOG2 + SPR_H_LOG2;

  logic                  pos_wr;
  logic [9:0]            pos_x_in;
  logic [9:0]            pos_y_in;
  logic [FRAME_BITS-1:0] frame_in;
`ifdef SPRITE_HFLIP_EN
  logic                  hflip_in;
`endif
  logic                  pos_pending;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;

`ifdef SPRITE_HFLIP_EN
  modport master (
    output pos_wr, pos_x_in, pos_y_in, frame_in, hflip_in, rom_data,
    input  pos_pending, rom_addr
  );
  modport slave (
    input  pos_wr, pos_x_in, pos_y_in, frame_in, hflip_in, rom_data,
    output pos_pending, rom_addr
  );
`else
  modport master (
    output pos_wr, pos_x_in, pos_y_in, frame_in, rom_data,
    input  pos_pending, rom_addr
  );
  modport slave (
    input  pos_wr, pos_x_in, pos_y_in, frame_in, rom_data,
    output pos_pending, rom_addr
  );
`endif
endinterface

// File: rtl/sprite_pixel_fetch.sv
// Single-sprite pixel source: box test, synchronous ROM fetch, 3-cycle aligned pixel output.
// Optional horizontal flip enabled by defining SPRITE_HFLIP_EN.
module sprite_pixel_fetch #(
  parameter int DATA_WIDTH = 24,
  parameter int SPR_W_LOG2 = 5,
  parameter int SPR_H_LOG2 = 5,
  parameter int FRAME_BITS = 2,
  parameter int V_ACTIVE   = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  input  logic                  bright,
  sprite_pixel_fetch_if.slave   bus,
  output logic [DATA_WIDTH-1:0] pixel,
  output logic                  pix_en,
  output logic [9:0]            hcount_out,
  output logic [9:0]            vcount_out,
  output logic                  bright_out
);
  localparam int ADDR_WIDTH = FRAME_BITS + SPR_W_LOG2 + SPR_H_LOG2;
  localparam logic [10:0] SPR_W = 11'(1 << SPR_W_LOG2);
  localparam logic [10:0] SPR_H = 11'(1 << SPR_H_LOG2);

  logic [9:0]            act_x, act_y, stage_x, stage_y;
  logic [FRAME_BITS-1:0] act_frame, stage_frame;
  logic                  pending;
  logic                  commit;
`ifdef SPRITE_HFLIP_EN
  logic                  act_flip, stage_flip;
`endif

  logic                  in_box;
  logic [SPR_W_LOG2-1:0] col;
  logic [SPR_H_LOG2-1:0] row;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic [1:0]            box_pipe;
  logic [2:0][9:0]       h_pipe, v_pipe;
  logic [2:0]            b_pipe;

  assign commit          = (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));
  assign bus.pos_pending = pending;
  assign bus.rom_addr    = rom_addr_q;

  // Staging takes every write; active state only changes on the commit cycle,
  // which always sees the staging contents from before a same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_x       <= 10'h3FF;
      act_y       <= 10'h3FF;
      act_frame   <= '0;
      stage_x     <= '0;
      stage_y     <= '0;
      stage_frame <= '0;
      pending     <= 1'b0;
`ifdef SPRITE_HFLIP_EN
      act_flip    <= 1'b0;
      stage_flip  <= 1'b0;
`endif
    end else begin
      if (commit && pending) begin
        act_x     <= stage_x;
        act_y     <= stage_y;
        act_frame <= stage_frame;
`ifdef SPRITE_HFLIP_EN
        act_flip  <= stage_flip;
`endif
      end
      if (bus.pos_wr) begin
        stage_x     <= bus.pos_x_in;
        stage_y     <= bus.pos_y_in;
        stage_frame <= bus.frame_in;
`ifdef SPRITE_HFLIP_EN
        stage_flip  <= bus.hflip_in;
`endif
        pending     <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  // Box bounds are widened to 11 bits so a sprite hanging off the right or
  // bottom edge clips instead of wrapping back to column/line 0.
  always_comb begin
    in_box = ({1'b0, hcount} >= {1'b0, act_x}) &&
             ({1'b0, hcount} <  ({1'b0, act_x} + SPR_W)) &&
             ({1'b0, vcount} >= {1'b0, act_y}) &&
             ({1'b0, vcount} <  ({1'b0, act_y} + SPR_H));
    row = vcount[SPR_H_LOG2-1:0] - act_y[SPR_H_LOG2-1:0];
    col = hcount[SPR_W_LOG2-1:0] - act_x[SPR_W_LOG2-1:0];
`ifdef SPRITE_HFLIP_EN
    if (act_flip) col = ~col;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q <= '0;
      box_pipe   <= '0;
      h_pipe     <= '0;
      v_pipe     <= '0;
      b_pipe     <= '0;
      pixel      <= '0;
      pix_en     <= 1'b0;
    end else begin
      if (in_box) rom_addr_q <= {act_frame, row, col};
      box_pipe <= {box_pipe[0], in_box};
      h_pipe   <= {h_pipe[1:0], hcount};
      v_pipe   <= {v_pipe[1:0], vcount};
      b_pipe   <= {b_pipe[1:0], bright};
      pix_en   <= box_pipe[1] & b_pipe[1];
      pixel    <= (box_pipe[1] & b_pipe[1]) ? bus.rom_data : '0;
    end
  end

  assign hcount_out = h_pipe[2];
  assign vcount_out = v_pipe[2];
  assign bright_out = b_pipe[2];
endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Scoreboard bench for sprite_pixel_fetch: sparse frame sweeps plus a directed vector table.
// Adds flip checks when SPRITE_HFLIP_EN is defined.
module tb_sprite_pixel_fetch;
  localparam int DW = 24;
  localparam int WL = 5;
  localparam int HL = 5;
  localparam int FB = 2;
  localparam int AW = FB + WL + HL;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    hcount, vcount;
  logic          bright;
  logic [DW-1:0] pixel;
  logic          pix_en;
  logic [9:0]    hcount_out, vcount_out;
  logic          bright_out;

  sprite_pixel_fetch_if #(.DATA_WIDTH(DW), .SPR_W_LOG2(WL), .SPR_H_LOG2(HL), .FRAME_BITS(FB)) bus ();

  sprite_pixel_fetch #(.DATA_WIDTH(DW), .SPR_W_LOG2(WL), .SPR_H_LOG2(HL),
                       .FRAME_BITS(FB), .V_ACTIVE(480)) dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .bright(bright),
    .bus(bus), .pixel(pixel), .pix_en(pix_en), .hcount_out(hcount_out),
    .vcount_out(vcount_out), .bright_out(bright_out)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] texel(input logic [AW-1:0] a);
    return {a, a};
  endfunction

  // Synchronous sprite ROM whose contents encode the address.
  always_ff @(posedge clk) bus.rom_data <= texel(bus.rom_addr);

  typedef struct {
    logic          en;
    logic [DW-1:0] pix;
    logic [9:0]    h;
    logic [9:0]    v;
    logic          b;
  } exp_t;

  typedef struct {
    int          v;
    int          h;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [FB-1:0] f;
    logic        fl;
  } wr_t;

  typedef struct {
    int            h;
    int            v;
    logic          en;
    logic [DW-1:0] pix;
  } vec_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  logic [9:0]    m_ax, m_ay, s_x, s_y;
  logic [FB-1:0] m_f, s_f;
  logic          m_flip, s_flip, m_pend;

  task automatic model_reset();
    m_ax = 10'h3FF; m_ay = 10'h3FF; m_f = '0; m_flip = 1'b0;
    s_x = '0; s_y = '0; s_f = '0; s_flip = 1'b0; m_pend = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [47:0] actual, input logic [47:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at t=%0t", name, actual, required, $time);
    end
  endtask

  // Drives one scan cycle, records its expected pipeline result and checks
  // whatever result is due three clocks after it was driven.
  task automatic apply_stimulus(input int h, input int v, input logic wr,
                                input logic [9:0] x, input logic [9:0] y,
                                input logic [FB-1:0] f, input logic fl,
                                input logic use_tab, input logic tab_en,
                                input logic [DW-1:0] tab_pix);
    logic [9:0]  h10, v10;
    logic [10:0] h11, v11;
    logic        box, b;
    logic [4:0]  c, r;
    exp_t        e, got;
    h10 = 10'(h); v10 = 10'(v);
    h11 = {1'b0, h10}; v11 = {1'b0, v10};
    b = (h < 640) && (v < 480);
    hcount = h10; vcount = v10; bright = b;
    bus.pos_wr = wr; bus.pos_x_in = x; bus.pos_y_in = y; bus.frame_in = f;
`ifdef SPRITE_HFLIP_EN
    bus.hflip_in = fl;
`endif
    box = (h11 >= {1'b0, m_ax}) && (h11 < {1'b0, m_ax} + 11'd32) &&
          (v11 >= {1'b0, m_ay}) && (v11 < {1'b0, m_ay} + 11'd32);
    c = h10[4:0] - m_ax[4:0];
    if (m_flip) c = 5'd31 - c;
    r = v10[4:0] - m_ay[4:0];
    e.en  = box && b;
    e.pix = e.en ? texel({m_f, r, c}) : '0;
    if (use_tab) begin
      e.en  = tab_en;
      e.pix = tab_pix;
    end
    e.h = h10; e.v = v10; e.b = b;
    sb.push_back(e);
    if (h == 0 && v == 480 && m_pend) begin
      m_ax = s_x; m_ay = s_y; m_f = s_f; m_flip = s_flip; m_pend = 1'b0;
    end
    if (wr) begin
      s_x = x; s_y = y; s_f = f; s_flip = fl; m_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.pos_wr = 1'b0;
    check_output("pos_pending", 48'(bus.pos_pending), 48'(m_pend));
    check_output("en_without_bright", 48'(pix_en & ~bright_out), 48'd0);
    if (sb.size() == 3) begin
      got = sb.pop_front();
      check_output("pipe_out", {2'b0, pix_en, pixel, hcount_out, vcount_out, bright_out},
                   {2'b0, got.en, got.pix, got.h, got.v, got.b});
    end
  endtask

  function automatic logic line_of_interest(input int v);
    return (v <= 2) || (v >= 47 && v <= 53) || (v >= 78 && v <= 84) ||
           (v >= 466 && v <= 481) || (v >= 522);
  endfunction

  function automatic logic col_of_interest(input int h);
    return (h <= 2) || (h >= 97 && h <= 102) || (h >= 126 && h <= 134) ||
           (h >= 626 && h <= 642) || (h >= 797);
  endfunction

  // Sparse frame: full column subset on interesting lines, two cycles elsewhere.
  task automatic sweep_frame(input wr_t a, input wr_t b);
    for (int v = 0; v < 525; v++) begin
      for (int h = 0; h < 800; h++) begin
        if (line_of_interest(v) ? col_of_interest(h) : (h == 0 || h == 799)) begin
          if (v == a.v && h == a.h)
            apply_stimulus(h, v, 1'b1, a.x, a.y, a.f, a.fl, 1'b0, 1'b0, '0);
          else if (v == b.v && h == b.h)
            apply_stimulus(h, v, 1'b1, b.x, b.y, b.f, b.fl, 1'b0, 1'b0, '0);
          else
            apply_stimulus(h, v, 1'b0, 10'd0, 10'd0, '0, 1'b0, 1'b0, 1'b0, '0);
        end
      end
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++)
      apply_stimulus(799, 524, 1'b0, 10'd0, 10'd0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic reset_check(input string name);
    check_output(name, {pix_en, pixel, hcount_out, vcount_out, bright_out, bus.rom_addr, bus.pos_pending},
                 '0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[10];
    wr_t  no_wr, wa, wb;

    vecs[0] = '{99,  50, 1'b0, 24'h000000};
    vecs[1] = '{100, 50, 1'b1, 24'h400400};
    vecs[2] = '{105, 52, 1'b1, 24'h445445};
    vecs[3] = '{131, 81, 1'b1, 24'h7FF7FF};
    vecs[4] = '{132, 81, 1'b0, 24'h000000};
    vecs[5] = '{131, 82, 1'b0, 24'h000000};
    vecs[6] = '{100, 49, 1'b0, 24'h000000};
    vecs[7] = '{700, 60, 1'b0, 24'h000000};
    vecs[8] = '{116, 66, 1'b1, 24'h610610};
    vecs[9] = '{120, 200, 1'b0, 24'h000000};

    no_wr = '{-1, -1, 10'd0, 10'd0, '0, 1'b0};

    hcount = '0; vcount = '0; bright = 1'b0;
    bus.pos_wr = 1'b0; bus.pos_x_in = '0; bus.pos_y_in = '0; bus.frame_in = '0;
`ifdef SPRITE_HFLIP_EN
    bus.hflip_in = 1'b0;
`endif
    model_reset();
    rst = 1'b1;
    #2;
    reset_check("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: nothing written, sprite stays hidden for a whole frame.
    sweep_frame(no_wr, no_wr);

    // T2: mid-frame write becomes visible only in the following frame.
    wa = '{50, 0, 10'd100, 10'd50, 2'd1, 1'b0};
    sweep_frame(wa, no_wr);
    check_output("t2_committed", 48'(bus.pos_pending), 48'd0);
    sweep_frame(no_wr, no_wr);

    // T3: directed points inside/outside the 100,50 box with known texels.
    for (int i = 0; i < 10; i++)
      apply_stimulus(vecs[i].h, vecs[i].v, 1'b0, 10'd0, 10'd0, '0, 1'b0,
                     1'b1, vecs[i].en, vecs[i].pix);
    flush();

    // T6: asynchronous reset while sprite pixels are in flight.
    for (int h = 100; h <= 110; h++)
      apply_stimulus(h, 60, (h == 105), 10'd5, 10'd5, 2'd2, 1'b0, 1'b0, 1'b0, '0);
    check_output("mid_sprite_en", 48'(pix_en), 48'd1);
    rst = 1'b1;
    #1;
    reset_check("mid_frame_reset");
    sb.delete();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    sweep_frame(no_wr, no_wr);

    // T4: sprite near bottom-right corner clips with no wraparound.
    wa = '{50, 0, 10'd630, 10'd470, 2'd2, 1'b0};
    sweep_frame(wa, no_wr);
    sweep_frame(no_wr, no_wr);

    // T5: write on the commit cycle lands in staging for the frame after.
    wa = '{50, 0, 10'd96, 10'd60, 2'd3, 1'b0};
    wb = '{480, 0, 10'd120, 10'd45, 2'd0, 1'b0};
    sweep_frame(wa, wb);
    check_output("t5_pending_after_commit", 48'(bus.pos_pending), 48'd1);
    sweep_frame(no_wr, no_wr);
    check_output("t5_second_commit", 48'(bus.pos_pending), 48'd0);
    sweep_frame(no_wr, no_wr);

`ifdef SPRITE_HFLIP_EN
    wa = '{50, 0, 10'd100, 10'd50, 2'd1, 1'b1};
    sweep_frame(wa, no_wr);
    sweep_frame(no_wr, no_wr);
    apply_stimulus(131, 50, 1'b0, 10'd0, 10'd0, '0, 1'b0, 1'b1, 1'b1, 24'h400400);
    apply_stimulus(100, 50, 1'b0, 10'd0, 10'd0, '0, 1'b0, 1'b1, 1'b1, 24'h41F41F);
    flush();
`endif

    flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
